conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen.sv | 115 +++++++++++
 tb/tb_conv_window_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Optional sticky frame-sequence error output enabled by defining WINGEN_FRAME_ERR_EN.
module conv_window_gen #(
  parameter int WI    = 8,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iPixValid,
  input  logic [WI-1:0]   iPixel,
  input  logic            iSof,
  output logic            oValid,
  output logic [3*WI-1:0] oWindowRow1,
  output logic [3*WI-1:0] oWindowRow2,
  output logic [3*WI-1:0] oWindowRow3,
  output logic            oMapDone
`ifdef WINGEN_FRAME_ERR_EN
  ,
  output logic            oFrameErr
`endif
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic          x_last, y_last;
  logic          win_ok;
  logic          last_win;

  logic [WI-1:0] lb0 [IMG_W];
  logic [WI-1:0] lb1 [IMG_W];
  logic [WI-1:0] win   [3][3];
  logic [WI-1:0] win_n [3][3];

  // iSof overrides the counters so the current pixel is always (0,0).
  always_comb begin
    cx     = iSof ? '0 : x;
    cy     = iSof ? '0 : y;
    x_last = (cx == XW'(IMG_W - 1));
    y_last = (cy == YW'(IMG_H - 1));
    win_ok = (cx >= XW'(2)) && (cy >= YW'(2));
  end

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      win_n[r][0] = win[r][1];
      win_n[r][1] = win[r][2];
    end
    win_n[0][2] = lb0[cx];
    win_n[1][2] = lb1[cx];
    win_n[2][2] = iPixel;
  end

  always_ff @(posedge iClk) begin
    if (!iRst && iPixValid) begin
      lb0[cx] <= lb1[cx];
      lb1[cx] <= iPixel;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      x           <= '0;
      y           <= '0;
      oValid      <= 1'b0;
      oMapDone    <= 1'b0;
      last_win    <= 1'b0;
      oWindowRow1 <= '0;
      oWindowRow2 <= '0;
      oWindowRow3 <= '0;
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      oValid   <= 1'b0;
      last_win <= 1'b0;
      oMapDone <= oValid && last_win;
      if (iPixValid) begin
        win <= win_n;
        x   <= x_last ? '0 : cx + XW'(1);
        y   <= x_last ? (y_last ? '0 : cy + YW'(1)) : cy;
        if (win_ok) begin
          oValid      <= 1'b1;
          last_win    <= x_last && y_last;
          oWindowRow1 <= {win_n[0][0], win_n[0][1], win_n[0][2]};
          oWindowRow2 <= {win_n[1][0], win_n[1][1], win_n[1][2]};
          oWindowRow3 <= {win_n[2][0], win_n[2][1], win_n[2][2]};
        end
      end
    end
  end

`ifdef WINGEN_FRAME_ERR_EN
  logic frame_done;

  // frame_done is only set across the gap between a frame's last pixel and the next accepted pixel.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oFrameErr  <= 1'b0;
      frame_done <= 1'b0;
    end else if (iPixValid) begin
      frame_done <= (x == XW'(IMG_W - 1)) && (y == YW'(IMG_H - 1)) && !iSof
                    || (iSof && x_last && y_last);
      if (iSof && ((x != '0) || (y != '0)))
        oFrameErr <= 1'b1;
      if (!iSof && (x == '0) && (y == '0) && frame_done)
        oFrameErr <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen using a ramp image model p(y,x)=(y*28+x) mod 256.
// Frame-error checks compile only when WINGEN_FRAME_ERR_EN is defined.
module tb_conv_window_gen;

  localparam int W = 28;
  localparam int H = 28;

  logic        clk;
  logic        iRst, iPixValid, iSof;
  logic [7:0]  iPixel;
  logic        oValid, oMapDone;
  logic [23:0] oWindowRow1, oWindowRow2, oWindowRow3;
`ifdef WINGEN_FRAME_ERR_EN
  logic        oFrameErr;
`endif

  conv_window_gen #(.WI(8), .IMG_W(W), .IMG_H(H)) dut (
    .iClk(clk), .iRst(iRst), .iPixValid(iPixValid), .iPixel(iPixel), .iSof(iSof),
    .oValid(oValid), .oWindowRow1(oWindowRow1), .oWindowRow2(oWindowRow2),
    .oWindowRow3(oWindowRow3), .oMapDone(oMapDone)
`ifdef WINGEN_FRAME_ERR_EN
    , .oFrameErr(oFrameErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] w;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  int          cmp, mis;
  int          valid_cnt, done_cnt;
  bit          prev_last;
  logic [71:0] first_obs, last_obs;
  bit          seen_first;

  function automatic logic [7:0] pix(int r, int c);
    int v;
    v = (r * W + c) % 256;
    return v[7:0];
  endfunction

  function automatic logic [71:0] win_of(int y, int x);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], pix(y - 2 + i, x - 2 + j)};
    return w;
  endfunction

  // One clock: drive inputs, let the edge happen, then score the registered outputs.
  task automatic cycle(input logic pv, input logic sof, input logic [7:0] p, input logic rst);
    exp_t        e;
    logic [71:0] obs;
    bit          was_last;
    bit          want_valid;
    iRst = rst; iPixValid = pv; iSof = sof; iPixel = p;
    @(posedge clk);
    @(negedge clk);
    iRst = 1'b0; iPixValid = 1'b0; iSof = 1'b0;
    if (rst) begin
      prev_last = 1'b0;
      return;
    end
    obs      = {oWindowRow1, oWindowRow2, oWindowRow3};
    was_last = 1'b0;
    if (!pv) begin
      cmp++;
      if (oValid !== 1'b0) begin
        mis++;
        $display("FAIL gap_valid: oValid=%b required 0 after idle cycle", oValid);
      end
    end
    want_valid = (sb.size() != 0);
    cmp++;
    if (oValid !== want_valid) begin
      mis++;
      $display("FAIL valid: oValid=%b required %b", oValid, want_valid);
    end
    if (oValid === 1'b1 && want_valid) begin
      e = sb.pop_front();
      cmp++;
      if (obs !== e.w) begin
        mis++;
        $display("FAIL window: got %h required %h", obs, e.w);
      end
      if (!seen_first) first_obs = obs;
      seen_first = 1'b1;
      last_obs   = obs;
      valid_cnt++;
      was_last = e.last;
    end else if (want_valid) begin
      void'(sb.pop_front());
    end
    cmp++;
    if (oMapDone !== prev_last) begin
      mis++;
      $display("FAIL map_done: oMapDone=%b required %b", oMapDone, prev_last);
    end
    if (oMapDone === 1'b1) begin
      done_cnt++;
      cmp++;
      if (oValid !== 1'b0) begin
        mis++;
        $display("FAIL done_valid: oValid=%b required 0 in map-done cycle", oValid);
      end
    end
    prev_last = was_last;
  endtask

  task automatic send_pix(input int y, input int x, input logic sof);
    exp_t e;
    if (y >= 2 && x >= 2) begin
      e.w    = win_of(y, x);
      e.last = (y == H - 1) && (x == W - 1);
      sb.push_back(e);
    end
    cycle(1'b1, sof, pix(y, x), 1'b0);
  endtask

  task automatic send_frame(input int npix, input bit gaps);
    for (int idx = 0; idx < npix; idx++) begin
      send_pix(idx / W, idx % W, idx == 0);
      if (gaps) begin
        cycle(1'b0, 1'b0, 8'hA5, 1'b0);
        if (idx % 50 == 49)
          repeat ($urandom_range(1, 5)) cycle(1'b0, 1'b1, 8'h5A, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    sb.delete();
    cycle(1'b1, 1'b0, 8'hFF, 1'b1);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
  endtask

  task automatic check_frame(input string name, input int v0, input int d0,
                             input int nwin, input int ndone);
    cmp++;
    if (valid_cnt - v0 != nwin) begin
      mis++;
      $display("FAIL %s_count: windows=%0d required %0d", name, valid_cnt - v0, nwin);
    end
    cmp++;
    if (done_cnt - d0 != ndone) begin
      mis++;
      $display("FAIL %s_done: pulses=%0d required %0d", name, done_cnt - d0, ndone);
    end
    cmp++;
    if (sb.size() != 0) begin
      mis++;
      $display("FAIL %s_pending: %0d windows never produced, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    cmp++;
    if ({oValid, oMapDone, oWindowRow1, oWindowRow2, oWindowRow3} !== '0) begin
      mis++;
      $display("FAIL reset_outputs: got %b %b %h %h %h required all 0",
               oValid, oMapDone, oWindowRow1, oWindowRow2, oWindowRow3);
    end
  endtask

  task automatic test_continuous();
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt; seen_first = 1'b0;
    send_frame(W * H, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_frame("cont", v0, d0, (W - 2) * (H - 2), 1);
    cmp++;
    if (first_obs !== 72'h000102_1C1D1E_38393A) begin
      mis++;
      $display("FAIL first_window: got %h required 0001021c1d1e38393a", first_obs);
    end
    cmp++;
    if (last_obs !== 72'hD5D6D7_F1F2F3_0D0E0F) begin
      mis++;
      $display("FAIL last_window: got %h required d5d6d7f1f2f30d0e0f", last_obs);
    end
  endtask

  task automatic test_gaps();
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    send_frame(W * H, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_frame("gaps", v0, d0, (W - 2) * (H - 2), 1);
  endtask

  task automatic test_reset_midframe();
    int v0, d0;
    send_frame(300, 1'b0);
    cmp++;
    if (sb.size() != 0) begin
      mis++;
      $display("FAIL pre_reset_pending: %0d windows outstanding, required 0", sb.size());
    end
    cycle(1'b1, 1'b0, pix(300 / W, 300 % W), 1'b1);
    cmp++;
    if ({oValid, oMapDone, oWindowRow1, oWindowRow2, oWindowRow3} !== '0) begin
      mis++;
      $display("FAIL midframe_reset: got %b %b %h %h %h required all 0",
               oValid, oMapDone, oWindowRow1, oWindowRow2, oWindowRow3);
    end
    v0 = valid_cnt; d0 = done_cnt; seen_first = 1'b0;
    send_frame(W * H, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_frame("rst_mid", v0, d0, (W - 2) * (H - 2), 1);
    cmp++;
    if (first_obs !== 72'h000102_1C1D1E_38393A || last_obs !== 72'hD5D6D7_F1F2F3_0D0E0F) begin
      mis++;
      $display("FAIL rst_mid_ends: first %h last %h required 0001021c1d1e38393a d5d6d7f1f2f30d0e0f",
               first_obs, last_obs);
    end
  endtask

  task automatic test_back_to_back();
    int v0, d0;
    v0 = valid_cnt; d0 = done_cnt;
    send_frame(W * H, 1'b0);
    send_frame(W * H, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_frame("b2b", v0, d0, 2 * (W - 2) * (H - 2), 2);
  endtask

`ifdef WINGEN_FRAME_ERR_EN
  task automatic test_frame_err();
    do_reset();
    send_frame(100, 1'b0);
    cmp++;
    if (oFrameErr !== 1'b0) begin
      mis++;
      $display("FAIL err_clean: oFrameErr=%b required 0", oFrameErr);
    end
    sb.delete();
    send_pix(0, 0, 1'b1);
    cmp++;
    if (oFrameErr !== 1'b1) begin
      mis++;
      $display("FAIL err_set: oFrameErr=%b required 1", oFrameErr);
    end
    for (int i = 1; i < 20; i++) send_pix(0, i, 1'b0);
    cmp++;
    if (oFrameErr !== 1'b1) begin
      mis++;
      $display("FAIL err_sticky: oFrameErr=%b required 1", oFrameErr);
    end
    do_reset();
    cmp++;
    if (oFrameErr !== 1'b0) begin
      mis++;
      $display("FAIL err_reset: oFrameErr=%b required 0", oFrameErr);
    end
  endtask
`endif

  initial begin
    cmp = 0; mis = 0; valid_cnt = 0; done_cnt = 0;
    prev_last = 1'b0; seen_first = 1'b0;
    first_obs = '0; last_obs = '0;
    iRst = 1'b1; iPixValid = 1'b0; iSof = 1'b0; iPixel = '0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
`ifdef WINGEN_FRAME_ERR_EN
    test_frame_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
